// File: rtl/bt_seg_cmd_ctrl_pkg.sv
// Shared definitions for the Bluetooth 7-segment command controller:
// ASCII protocol constants, FSM state type, active-low segment patterns
// and the ASCII hex-digit parser.
package bt_seg_cmd_ctrl_pkg;

    localparam logic [7:0] CH_HASH = 8'h23;  // '#': frame start
    localparam logic [7:0] CH_ACK  = 8'h4B;  // 'K': frame accepted
    localparam logic [7:0] CH_ERR  = 8'h45;  // 'E': frame rejected
    localparam logic [7:0] CH_ZERO = 8'h30;  // '0': base of index characters

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_IDX,
        ST_GET_VAL,
        ST_RESP
    } state_t;

    // {g,f,e,d,c,b,a}, active-low; element [n] is the glyph for hex value n
    localparam logic [15:0][6:0] SEG_PAT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Returns {valid, nibble} for '0'-'9', 'A'-'F', 'a'-'f'.
    // Letters share low bits 1..6 in both cases, so nibble = low bits + 9.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

endpackage

// File: rtl/bt_seg_cmd_ctrl_seg7.sv
// seg7_hex_decoder: combinational 4-bit value to 7-segment pattern.
// Ports:
//   value  in   4  hex value to display
//   seg    out  7  {g,f,e,d,c,b,a}, active-low
module seg7_hex_decoder
    import bt_seg_cmd_ctrl_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_PAT[value];
    end

endmodule

// File: rtl/bt_seg_cmd_ctrl.sv
// bt_seg_cmd_ctrl: parses '#', index, hex-value frames from the UART receiver,
// writes the digit registers, answers 'K'/'E' on the UART transmit handshake,
// counts frame errors on led and scans the multiplexed 7-segment display.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_valid, rx_data  one-cycle received-byte strobe and byte
//   tx_ready           transmitter accepts a byte this cycle
//   tx_valid, tx_data  response byte pending / response byte (held while pending)
//   seg                active-low segments {g,f,e,d,c,b,a} of the enabled digit
//   dig_an             active-low digit enables, exactly one low
//   led                saturating frame-error count
module bt_seg_cmd_ctrl
    import bt_seg_cmd_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCAN_DIV    = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_an,
    output logic [5:0]            led
);

    localparam int unsigned PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SW = $clog2(SCAN_DIV + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [5:0]      led_q;
    logic [3:0]      digit_q [NUM_DIGITS];
    logic            wr_en;
    logic            err_inc;
    logic [4:0]      hex;
    logic            idx_ok;

    logic [SW-1:0]         scnt_q;
    logic [PW-1:0]         ptr_q, ptr_next;
    logic                  scan_wrap;
    logic [6:0]            seg_next;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_an_q;

    assign hex    = hex_decode(rx_data);
    assign idx_ok = (rx_data >= CH_ZERO) && (32'(rx_data - CH_ZERO) < NUM_DIGITS);

    // Timeout counter defaults to 0, so it is held at 0 in IDLE/RESP and
    // cleared by every received byte. Leaving on the compare against
    // TIMEOUT_CYC-1 means the frame is dropped on the edge the count
    // would reach TIMEOUT_CYC.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        tcnt_d    = '0;
        wr_en     = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == CH_HASH)
                    state_d = ST_GET_IDX;
            end
            ST_GET_IDX: begin
                if (rx_valid) begin
                    if (idx_ok) begin
                        idx_d   = PW'(rx_data - CH_ZERO);
                        state_d = ST_GET_VAL;
                    end else begin
                        tx_data_d = CH_ERR;
                        err_inc   = 1'b1;
                        state_d   = ST_RESP;
                    end
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_GET_VAL: begin
                if (rx_valid) begin
                    if (hex[4]) begin
                        wr_en     = 1'b1;
                        tx_data_d = CH_ACK;
                    end else begin
                        tx_data_d = CH_ERR;
                        err_inc   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_RESP: begin
                // bytes arriving while a response is pending are dropped and counted
                if (rx_valid)
                    err_inc = 1'b1;
                if (tx_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tx_data_q <= '0;
            tcnt_q    <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            tcnt_q    <= tcnt_d;
            if (err_inc && led_q != '1)
                led_q <= led_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
                digit_q[i] <= '0;
        end else if (wr_en) begin
            digit_q[idx_q] <= hex[3:0];
        end
    end

    // Scan: the decoder looks at the digit about to be enabled so that seg and
    // dig_an are loaded on the same edge, once per slot.
    assign scan_wrap = (scnt_q == SW'(SCAN_DIV - 1));

    always_comb begin
        ptr_next = ptr_q;
        if (scan_wrap)
            ptr_next = (ptr_q == PW'(NUM_DIGITS - 1)) ? '0 : ptr_q + PW'(1);
    end

    seg7_hex_decoder u_dec (
        .value (digit_q[ptr_next]),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q   <= '0;
            ptr_q    <= '0;
            seg_q    <= SEG_PAT[0];
            dig_an_q <= ~NUM_DIGITS'(1);
        end else begin
            scnt_q <= scan_wrap ? '0 : scnt_q + SW'(1);
            if (scan_wrap) begin
                ptr_q    <= ptr_next;
                seg_q    <= seg_next;
                dig_an_q <= ~(NUM_DIGITS'(1) << ptr_next);
            end
        end
    end

    assign tx_valid = (state_q == ST_RESP);
    assign tx_data  = tx_data_q;
    assign seg      = seg_q;
    assign dig_an   = dig_an_q;
    assign led      = led_q;

endmodule

// File: tb/tb_bt_seg_cmd_ctrl.sv
// Self-checking bench for bt_seg_cmd_ctrl: directed scenarios plus randomized
// frames, compared against a frame-level reference model of the protocol.
module tb_bt_seg_cmd_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 16;
    localparam int unsigned TO = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [6:0]    seg;
    logic [ND-1:0] dig_an;
    logic [5:0]    led;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int         m_digit [ND];
    int         m_led;
    bit         m_resp;
    logic [7:0] m_resp_byte;
    logic [7:0] m_frame [$];
    int         m_idle;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    bt_seg_cmd_ctrl #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .seg      (seg),
        .dig_an   (dig_an),
        .led      (led)
    );

    always #5 clk = ~clk;

    function automatic int hex_val(input logic [7:0] b);
        int c;
        c = int'(b);
        if (c >= 48 && c <= 57)  return c - 48;
        if (c >= 65 && c <= 70)  return c - 65 + 10;
        if (c >= 97 && c <= 102) return c - 97 + 10;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_digit[i] = 0;
        m_led = 0;
        m_resp = 0;
        m_resp_byte = 8'h00;
        m_frame.delete();
        m_idle = 0;
    endtask

    task automatic model_respond(input logic [7:0] c);
        m_frame.delete();
        m_resp = 1;
        m_resp_byte = c;
        if (c == 8'h45 && m_led < 63) m_led++;
    endtask

    // One clock of the protocol: collect bytes of a frame, decide at its end.
    task automatic model_step(input bit v, input logic [7:0] b, input bit rdy);
        if (m_resp) begin
            if (v && m_led < 63) m_led++;
            if (rdy) m_resp = 0;
        end else if (v) begin
            m_idle = 0;
            if (m_frame.size() == 0) begin
                if (b == 8'h23) m_frame.push_back(b);
            end else if (m_frame.size() == 1) begin
                if (int'(b) >= 48 && int'(b) < 48 + int'(ND)) m_frame.push_back(b);
                else model_respond(8'h45);
            end else begin
                if (hex_val(b) >= 0) begin
                    m_digit[int'(m_frame[1]) - 48] = hex_val(b);
                    model_respond(8'h4B);
                end else begin
                    model_respond(8'h45);
                end
            end
        end else if (m_frame.size() != 0) begin
            m_idle++;
            if (m_idle >= int'(TO)) begin
                m_frame.delete();
                m_idle = 0;
            end
        end
    endtask

    // Drive one clock of inputs, advance the model, compare handshake outputs.
    task automatic cycle(input bit v, input logic [7:0] b, input bit rdy);
        rx_valid = v;
        rx_data  = b;
        tx_ready = rdy;
        @(negedge clk);
        rx_valid = 1'b0;
        model_step(v, b, rdy);
        nvec++;
        if (tx_valid !== m_resp) begin
            nerr++;
            $display("FAIL tx_valid @%0t: got %b expected %b", $time, tx_valid, m_resp);
        end
        if (m_resp) begin
            nvec++;
            if (tx_data !== m_resp_byte) begin
                nerr++;
                $display("FAIL tx_data @%0t: got %h expected %h", $time, tx_data, m_resp_byte);
            end
        end
        nvec++;
        if (led !== 6'(m_led)) begin
            nerr++;
            $display("FAIL led @%0t: got %0d expected %0d", $time, led, m_led);
        end
    endtask

    task automatic check_display();
        int hits [ND];
        repeat ((ND + 1) * SD) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < ND; i++) hits[i] = 0;
        for (int c = 0; c < int'(ND * SD); c++) begin
            int k;
            k = -1;
            for (int i = 0; i < ND; i++) if (dig_an[i] === 1'b0) k = i;
            nvec++;
            if ($countones(~dig_an) != 1 || k < 0) begin
                nerr++;
                $display("FAIL dig_an_onehot @%0t: got %b expected one bit low", $time, dig_an);
            end else begin
                hits[k]++;
                nvec++;
                if (seg !== seg_tab[m_digit[k]]) begin
                    nerr++;
                    $display("FAIL seg digit%0d @%0t: got %b expected %b", k, $time, seg,
                             seg_tab[m_digit[k]]);
                end
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < ND; i++) begin
            nvec++;
            if (hits[i] != int'(SD)) begin
                nerr++;
                $display("FAIL scan_slot digit%0d: got %0d cycles expected %0d", i, hits[i], SD);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        nvec++;
        if (seg !== 7'b1000000) begin
            nerr++; $display("FAIL %s seg: got %b expected 1000000", tag, seg);
        end
        nvec++;
        if (dig_an !== 4'b1110) begin
            nerr++; $display("FAIL %s dig_an: got %b expected 1110", tag, dig_an);
        end
        nvec++;
        if (tx_valid !== 1'b0) begin
            nerr++; $display("FAIL %s tx_valid: got %b expected 0", tag, tx_valid);
        end
        nvec++;
        if (tx_data !== 8'h00) begin
            nerr++; $display("FAIL %s tx_data: got %h expected 00", tag, tx_data);
        end
        nvec++;
        if (led !== 6'd0) begin
            nerr++; $display("FAIL %s led: got %0d expected 0", tag, led);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_ack();
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h32, 1'b1);
        cycle(1'b1, 8'h41, 1'b1);
        nvec++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
            nerr++; $display("FAIL ack_resp: got %b/%h expected 1/4b", tx_valid, tx_data);
        end
        cycle(1'b0, 8'h00, 1'b1);
        nvec++;
        if (tx_valid !== 1'b0) begin
            nerr++; $display("FAIL ack_drop: got %b expected 0", tx_valid);
        end
        check_display();
    endtask

    task automatic test_bad_index();
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h37, 1'b1);
        nvec++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h45 || led !== 6'd1) begin
            nerr++;
            $display("FAIL bad_index: got %b/%h/%0d expected 1/45/1", tx_valid, tx_data, led);
        end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h35, 1'b1);
        nvec++;
        if (tx_valid !== 1'b0 || led !== 6'd1) begin
            nerr++; $display("FAIL idle_ignore: got %b/%0d expected 0/1", tx_valid, led);
        end
        check_display();
    endtask

    task automatic test_bad_value_stall();
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h31, 1'b1);
        cycle(1'b1, 8'h67, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            nvec++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin
                nerr++; $display("FAIL stall_hold %0d: got %b/%h expected 1/45", i, tx_valid, tx_data);
            end
        end
        cycle(1'b1, 8'h58, 1'b0);
        nvec++;
        if (led !== 6'd3 || tx_data !== 8'h45) begin
            nerr++; $display("FAIL resp_drop: got led %0d data %h expected 3/45", led, tx_data);
        end
        cycle(1'b0, 8'h00, 1'b1);
        nvec++;
        if (tx_valid !== 1'b0) begin
            nerr++; $display("FAIL stall_release: got %b expected 0", tx_valid);
        end
        check_display();
    endtask

    task automatic test_timeout();
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        repeat (TO) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h35, 1'b1);
        nvec++;
        if (tx_valid !== 1'b0 || led !== 6'd3) begin
            nerr++; $display("FAIL timeout_abandon: got %b/%0d expected 0/3", tx_valid, led);
        end
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        cycle(1'b1, 8'h66, 1'b1);
        nvec++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
            nerr++; $display("FAIL timeout_recover: got %b/%h expected 1/4b", tx_valid, tx_data);
        end
        check_display();
        // one cycle short of the limit the frame is still alive
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h30, 1'b1);
        repeat (TO - 1) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h63, 1'b1);
        nvec++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
            nerr++; $display("FAIL timeout_edge: got %b/%h expected 1/4b", tx_valid, tx_data);
        end
        check_display();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 70; i++) begin
            cycle(1'b1, 8'h23, 1'b1);
            cycle(1'b1, 8'h39, 1'b1);
            cycle(1'b0, 8'h00, 1'b1);
        end
        nvec++;
        if (led !== 6'd63) begin
            nerr++; $display("FAIL led_saturate: got %0d expected 63", led);
        end
        cycle(1'b1, 8'h23, 1'b0);
        cycle(1'b1, 8'h39, 1'b0);
        cycle(1'b1, 8'h41, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        nvec++;
        if (led !== 6'd63 || tx_valid !== 1'b1 || tx_data !== 8'h45) begin
            nerr++;
            $display("FAIL sat_resp_drop: got %0d/%b/%h expected 63/1/45", led, tx_valid, tx_data);
        end
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            nvec++;
            if (tx_valid !== 1'b0) begin
                nerr++; $display("FAIL no_second_resp %0d: got %b expected 0", i, tx_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h32, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_get_val");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 8'h23, 1'b1);
        cycle(1'b1, 8'h31, 1'b1);
        cycle(1'b1, 8'h37, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_resp");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        check_display();
    endtask

    task automatic test_random();
        logic [7:0] bad_val [6] = '{8'h47, 8'h2F, 8'h3A, 8'h40, 8'h67, 8'h20};
        logic [7:0] bytes [$];
        for (int f = 0; f < 120; f++) begin
            int kind, n;
            bytes.delete();
            kind = int'($urandom_range(0, 5));
            n    = int'($urandom_range(0, 15));
            bytes.push_back(8'h23);
            if (kind == 3) bytes.push_back(8'(48 + ND + $urandom_range(0, 5)));
            else           bytes.push_back(8'(48 + $urandom_range(0, ND - 1)));
            if (kind == 4)      bytes.push_back(bad_val[$urandom_range(0, 5)]);
            else if (n < 10)    bytes.push_back(8'(48 + n));
            else if (kind == 1) bytes.push_back(8'(87 + n));
            else                bytes.push_back(8'(55 + n));
            if (kind == 5) bytes.push_front(8'($urandom_range(0, 255)));
            foreach (bytes[i]) begin
                cycle(1'b1, bytes[i], 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
            end
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        check_display();
    endtask

    initial begin
        test_reset();
        test_ack();
        test_bad_index();
        test_bad_value_stall();
        test_timeout();
        test_saturate();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
